// File: rtl/pm1_cap_pkg.sv
// pm1_cap_pkg: shared widths, pm1 bit positions, capture states and event layout.
package pm1_cap_pkg;
  localparam int PM1_W = 13;
  localparam int PM1_TS_W = 8;
  localparam int R_BIT = 0, S_BIT = 1, T_BIT = 2, U_BIT = 3, V_BIT = 4, W_BIT = 5, X_BIT = 6;
  localparam int Y_BIT = 7, Z_BIT = 8, A0_BIT = 9, B0_BIT = 10, C0_BIT = 11, D0_BIT = 12;
  typedef enum logic {PRIME, RUN} cap_state_t;
  typedef struct packed {
    logic [PM1_TS_W-1:0] ts;
    logic [PM1_W-1:0]    word;
  } evt_t;
endpackage

// File: rtl/pm1_cap_fifo.sv
// pm1_cap_fifo: synchronous FIFO whose head is read straight from the storage registers.
module pm1_cap_fifo #(
  parameter int DW    = 21,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout  = mem_q[rd_q];
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/pm1_event_capture.sv
// pm1_event_capture: timestamps every change of the pm1 outputs and queues it for a
// valid/ready consumer, counting events lost to a full queue.
module pm1_event_capture
  import pm1_cap_pkg::*;
#(
  parameter int W     = PM1_W,
  parameter int TS_W  = PM1_TS_W,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sample_en,
  input  logic [W-1:0]     pm1_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [W+TS_W-1:0] evt_data,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [7:0]       drop_cnt
);
  cap_state_t      state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [W-1:0]    last_q, last_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_q, drop_d;
  logic            evt, push, pop, drop, full, empty;
  always_comb begin
    evt        = sample_en && state_q == RUN && pm1_out != last_q;
    pop        = !empty && evt_ready;
    push       = evt && (!full || pop);
    drop       = evt && full && !pop;
    state_d    = sample_en ? RUN : state_q;
    ts_d       = ts_q + TS_W'(sample_en);
    last_d     = sample_en ? pm1_out : last_q;
    overflow_d = drop ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
    // A drop coinciding with a clear leaves a count of one.
    drop_d     = (clr_overflow ? 8'd0 : drop_q) + 8'(drop && (clr_overflow || drop_q != 8'hFF));
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= PRIME;
      ts_q       <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end
  pm1_cap_fifo #(.DW(W + TS_W), .DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    ({ts_q, pm1_out}),
    .dout   (evt_data),
    .full   (full),
    .empty  (empty)
  );
  assign evt_valid = !empty;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_pm1_event_capture.sv
// tb_pm1_event_capture: scenario tasks feeding a scoreboard that a beat monitor drains.
module tb_pm1_event_capture;
  import pm1_cap_pkg::*;
  logic        clock = 0, reset_n = 1, sample_en = 0, evt_ready = 0, clr_overflow = 0;
  logic [12:0] pm1_out = '0;
  logic        evt_valid, overflow;
  logic [20:0] evt_data;
  logic [7:0]  drop_cnt;
  logic [7:0]  tb_ts = '0;
  int          vectors = 0, miscompares = 0, beats = 0;
  evt_t        sb[$];
  evt_t        mon_exp;

  always #5 clock = ~clock;

  pm1_event_capture dut (
    .clock(clock), .reset_n(reset_n), .sample_en(sample_en), .pm1_out(pm1_out),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .overflow(overflow), .clr_overflow(clr_overflow), .drop_cnt(drop_cnt)
  );

  always @(negedge clock) begin
    if (reset_n && evt_valid && evt_ready) begin
      vectors++;
      beats++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL beat: got unexpected evt_data=%h, required none", evt_data);
      end else begin
        mon_exp = sb.pop_front();
        if (evt_data !== mon_exp) begin
          miscompares++;
          $display("FAIL beat: got evt_data=%h, required %h", evt_data, mon_exp);
        end
      end
    end
  end

  task automatic step();
    if (sample_en && reset_n) tb_ts++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0; sample_en = 0; evt_ready = 0; clr_overflow = 0; pm1_out = '0;
    sb.delete();
    tb_ts = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  task automatic wait_drain(output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 20; i++) begin
      if (!evt_valid) begin
        timed_out = 0;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", evt_valid); end
    vectors++; if (evt_data !== 21'h0) begin miscompares++; $display("FAIL reset_data: got %h required 0", evt_data); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt); end
  endtask

  task automatic test_prime();
    bit to;
    do_reset();
    sample_en = 1;
    pm1_out = 13'h1A5;
    repeat (3) begin
      step();
      vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL prime_valid: got %b required 0", evt_valid); end
    end
    pm1_out = 13'h1A6;
    evt_ready = 1;
    sb.push_back('{ts: 8'd3, word: 13'h1A6});
    step();
    sample_en = 0;
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL prime_first_evt: got %b required 1", evt_valid); end
    wait_drain(to);
    vectors++; if (to || sb.size() != 0) begin miscompares++; $display("FAIL prime_drain: got %0d left required 0", sb.size()); end
  endtask

  task automatic test_single_change();
    int b0;
    do_reset();
    sample_en = 1;
    pm1_out = 13'h0000;
    step();
    pm1_out = 13'h0001;
    evt_ready = 1;
    sb.push_back('{ts: 8'h01, word: 13'h0001});
    b0 = beats;
    step();
    sample_en = 0;
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency: got %b required 1", evt_valid); end
    vectors++; if (evt_data !== {8'h01, 13'h0001}) begin miscompares++; $display("FAIL single_data: got %h required %h", evt_data, {8'h01, 13'h0001}); end
    step();
    step();
    vectors++; if (evt_valid !== 1'b0 || beats - b0 != 1) begin miscompares++; $display("FAIL single_beats: got %0d required 1", beats - b0); end
  endtask

  task automatic test_overflow();
    int b0;
    bit to;
    do_reset();
    sample_en = 1;
    pm1_out = '0;
    step();
    for (int i = 1; i <= 6; i++) begin
      pm1_out = 13'(i);
      if (i <= 4) sb.push_back('{ts: 8'(i), word: 13'(i)});
      step();
    end
    sample_en = 0;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    vectors++; if (drop_cnt !== 8'd2) begin miscompares++; $display("FAIL ovf_drop_cnt: got %0d required 2", drop_cnt); end
    step();
    step();
    vectors++; if (evt_valid !== 1'b1 || evt_data !== {8'd1, 13'd1}) begin miscompares++; $display("FAIL ovf_hold: got v=%b d=%h required v=1 d=%h", evt_valid, evt_data, {8'd1, 13'd1}); end
    evt_ready = 1;
    b0 = beats;
    wait_drain(to);
    vectors++; if (to || sb.size() != 0 || beats - b0 != 4) begin miscompares++; $display("FAIL ovf_drain: got %0d beats required 4", beats - b0); end
  endtask

  task automatic test_back_to_back();
    int b0;
    bit to;
    do_reset();
    sample_en = 1;
    pm1_out = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      pm1_out = 13'(17 + i);
      sb.push_back('{ts: 8'(i + 1), word: 13'(17 + i)});
      step();
    end
    evt_ready = 1;
    pm1_out = 13'h15;
    sb.push_back('{ts: 8'd5, word: 13'h15});
    step();
    sample_en = 0;
    vectors++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin miscompares++; $display("FAIL b2b_no_drop: got ovf=%b cnt=%0d required 0/0", overflow, drop_cnt); end
    b0 = beats;
    wait_drain(to);
    vectors++; if (to || sb.size() != 0 || beats - b0 != 4) begin miscompares++; $display("FAIL b2b_occupancy: got %0d remaining beats required 4", beats - b0); end
  endtask

  task automatic test_ts_wrap();
    bit to;
    do_reset();
    sample_en = 1;
    pm1_out = 13'h055;
    repeat (256) step();
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_quiet: got %b required 0", evt_valid); end
    pm1_out = 13'h056;
    evt_ready = 1;
    sb.push_back('{ts: 8'h00, word: 13'h056});
    step();
    sample_en = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      pm1_out = 13'(256 + i);
      step();
      vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_frozen: got %b required 0", evt_valid); end
    end
    sample_en = 1;
    pm1_out = 13'h1FF;
    sb.push_back('{ts: 8'h01, word: 13'h1FF});
    step();
    sample_en = 0;
    wait_drain(to);
    vectors++; if (to || sb.size() != 0) begin miscompares++; $display("FAIL wrap_drain: got %0d left required 0", sb.size()); end
  endtask

  task automatic test_clr_saturate();
    bit to;
    do_reset();
    sample_en = 1;
    pm1_out = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      pm1_out = 13'(i + 1);
      sb.push_back('{ts: 8'(i + 1), word: 13'(i + 1)});
      step();
    end
    for (int i = 0; i < 260; i++) begin
      pm1_out = (i % 2 == 0) ? 13'h0AA : 13'h0BB;
      step();
    end
    vectors++; if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin miscompares++; $display("FAIL sat_drop_cnt: got %0d ovf=%b required 255/1", drop_cnt, overflow); end
    clr_overflow = 1;
    pm1_out = 13'h0CC;
    step();
    vectors++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin miscompares++; $display("FAIL clr_vs_drop: got %0d ovf=%b required 1/1", drop_cnt, overflow); end
    sample_en = 0;
    step();
    clr_overflow = 0;
    vectors++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL clr_only: got %0d ovf=%b required 0/0", drop_cnt, overflow); end
    evt_ready = 1;
    wait_drain(to);
    vectors++; if (to || sb.size() != 0) begin miscompares++; $display("FAIL clr_drain: got %0d left required 0", sb.size()); end
  endtask

  task automatic test_mid_reset();
    bit to;
    do_reset();
    sample_en = 1;
    pm1_out = '0;
    step();
    for (int i = 1; i <= 3; i++) begin
      pm1_out = 13'(64 + i);
      step();
    end
    sample_en = 0;
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL mid_queued: got %b required 1", evt_valid); end
    reset_n = 0;
    #1;
    vectors++; if (evt_valid !== 1'b0 || evt_data !== 21'h0) begin miscompares++; $display("FAIL mid_async: got v=%b d=%h required 0/0", evt_valid, evt_data); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_drop_cnt: got %0d required 0", drop_cnt); end
    sb.delete();
    tb_ts = '0;
    @(posedge clock);
    #1;
    reset_n = 1;
    sample_en = 1;
    pm1_out = 13'h777;
    step();
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reprime: got %b required 0", evt_valid); end
    pm1_out = 13'h778;
    evt_ready = 1;
    sb.push_back('{ts: 8'h01, word: 13'h778});
    step();
    sample_en = 0;
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL mid_after: got %b required 1", evt_valid); end
    wait_drain(to);
    vectors++; if (to || sb.size() != 0) begin miscompares++; $display("FAIL mid_drain: got %0d left required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_single_change();
    test_overflow();
    test_back_to_back();
    test_ts_wrap();
    test_clr_saturate();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
